// File: rtl/wb_burst_master.sv
`default_nettype none
// ============================================================================
//  Module   : wb_burst_master
//  Purpose  : Wishbone classic initiator. Runs one command at a time as a
//             sequence of single-beat reads or writes over consecutive word
//             addresses, fed by a write-data stream and draining into a
//             read-data stream.
//  Revision : 1.0  initial release
// ============================================================================
module wb_burst_master #(
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int LENW    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_reset_i,
    // command
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [AW-1:0]     cmd_addr,
    input  logic [LENW-1:0]   cmd_len,
    input  logic              cmd_we,
    // write-data stream
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DW-1:0]     wr_data,
    // read-data stream
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DW-1:0]     rd_data,
    // status
    output logic              busy,
    output logic              done,
    output logic              err,
    // wishbone
    output logic [AW-1:0]     wb_adr_o,
    output logic [DW-1:0]     wb_dat_o,
    input  logic [DW-1:0]     wb_dat_i,
    output logic              wb_we_o,
    output logic [DW/8-1:0]   wb_sel_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    input  logic              wb_ack_i,
    input  logic              wb_err_i
);

    // Counter only has to reach TIMEOUT-1: it counts completed REQ cycles.
    localparam int            TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WDAT  = 3'd1,
        S_REQ   = 3'd2,
        S_RHOLD = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t          state_q,   state_d;
    logic [AW-1:0]   addr_q,    addr_d;
    logic [LENW-1:0] cnt_q,     cnt_d;
    logic            we_q,      we_d;
    logic [DW-1:0]   wdat_q,    wdat_d;
    logic [DW-1:0]   rdat_q,    rdat_d;
    logic            rvld_q,    rvld_d;
    logic            started_q, started_d;   // a bus beat has been issued for this command
    logic            err_q,     err_d;
    logic [TW-1:0]   tmo_q,     tmo_d;
    logic            timeout;

    // Abort condition: the current beat has spent TIMEOUT cycles without a response.
    assign timeout = (TIMEOUT != 0) && (tmo_q == TMO_LAST);

    // Next-state and datapath updates; every register holds unless a state changes it.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        wdat_d    = wdat_q;
        rdat_d    = rdat_q;
        rvld_d    = rvld_q;
        started_d = started_q;
        err_d     = 1'b0;
        tmo_d     = '0;
        case (state_q)
            S_IDLE: begin
                started_d = 1'b0;
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    cnt_d   = cmd_len;
                    we_d    = cmd_we;
                    state_d = cmd_we ? S_WDAT : S_REQ;
                end
            end
            S_WDAT: begin
                if (wr_valid) begin
                    wdat_d  = wr_data;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                started_d = 1'b1;
                tmo_d     = tmo_q + 1'b1;
                if (wb_err_i || (!wb_ack_i && timeout)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (wb_ack_i) begin
                    if (!we_q) begin
                        rdat_d  = wb_dat_i;
                        rvld_d  = 1'b1;
                        state_d = S_RHOLD;
                    end else if (cnt_q == '0) begin
                        state_d = S_FIN;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        cnt_d   = cnt_q - 1'b1;
                        state_d = S_WDAT;
                    end
                end
            end
            S_RHOLD: begin
                if (rd_ready) begin
                    rvld_d = 1'b0;
                    if (cnt_q == '0) begin
                        state_d = S_FIN;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        cnt_d   = cnt_q - 1'b1;
                        state_d = S_REQ;
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any command in flight.
    always_ff @(posedge wb_clk_i or posedge wb_reset_i) begin
        if (wb_reset_i) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            wdat_q    <= '0;
            rdat_q    <= '0;
            rvld_q    <= 1'b0;
            started_q <= 1'b0;
            err_q     <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            wdat_q    <= wdat_d;
            rdat_q    <= rdat_d;
            rvld_q    <= rvld_d;
            started_q <= started_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
        end
    end

    // Bus and stream outputs decode straight from state so reset clears them at once.
    assign cmd_ready = (state_q == S_IDLE);
    assign wr_ready  = (state_q == S_WDAT);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_FIN);
    assign err       = err_q;
    assign rd_valid  = rvld_q;
    assign rd_data   = rdat_q;
    assign wb_adr_o  = addr_q;
    assign wb_dat_o  = wdat_q;
    assign wb_stb_o  = (state_q == S_REQ);
    assign wb_we_o   = wb_stb_o & we_q;
    assign wb_sel_o  = {(DW/8){wb_stb_o}};
    // cyc covers the whole burst once the first beat is out, including write-data waits.
    assign wb_cyc_o  = (state_q == S_REQ) || (state_q == S_RHOLD) ||
                       ((state_q == S_WDAT) && started_q);

endmodule
`default_nettype wire

// File: tb/tb_wb_burst_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_burst_master
//  Purpose  : Self-checking bench for wb_burst_master: Wishbone responder,
//             stream drivers and a per-command expected-transaction model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_burst_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic        wr_valid = 1'b0, wr_ready;
    logic [31:0] wr_data = '0;
    logic        rd_valid, rd_ready = 1'b1;
    logic [31:0] rd_data;
    logic        busy, done, err;
    logic [15:0] wb_adr_o;
    logic [31:0] wb_dat_o, wb_dat_i = '0;
    logic        wb_we_o, wb_cyc_o, wb_stb_o;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i = 1'b0, wb_err_i = 1'b0;

    always #5 clk = ~clk;

    wb_burst_master #(.AW(16), .DW(32), .LENW(8), .TIMEOUT(8)) dut (
        .wb_clk_i(clk), .wb_reset_i(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_we(cmd_we),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .done(done), .err(err),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_cyc_o(wb_cyc_o),
        .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    typedef struct {
        logic [15:0] adr;
        logic        we;
        logic [31:0] dat;
        logic        is_err;
    } beat_t;

    beat_t       beats[$];      // every beat the responder answered
    logic [31:0] rd_q[$];       // words taken from the read stream
    logic [31:0] wq[$];         // words still to offer on the write stream
    logic [31:0] exp_w[$];      // words the current write command must put on the bus
    logic [31:0] fixed_w[$];    // optional directed write words

    int errors = 0, checks = 0;
    int max_lat = 0, cur_lat = 0, wcnt = 0, err_at = -1, beat_idx = 0;
    bit noack = 1'b0;
    int wr_gap = 0, gap_left = 0, rd_mode = 0;
    bit wr_hs = 1'b0;
    logic [31:0] salt = 32'h1234_5678;
    int done_cnt, err_cnt, cyc_falls, sel_bad, both_bad, errcyc_bad, stb_cycles;
    int cyc_n = 0, stb_rise_cyc = 0, err_cyc = 0;
    bit prev_cyc = 1'b0, prev_stb = 1'b0;
    logic [15:0] cur_a;
    int cur_l;
    bit cur_w;

    // Responder memory contents: a fixed scramble of the address.
    function automatic logic [31:0] rdf(input logic [15:0] a);
        return {a, ~a} ^ salt;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wishbone responder: answers each strobe after a random latency (0 = same cycle).
    always @(negedge clk) begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        if (wb_cyc_o && wb_stb_o && !rst && !noack) begin
            if (wcnt >= cur_lat) begin
                if (beat_idx == err_at) begin
                    wb_err_i = 1'b1;
                end else begin
                    wb_ack_i = 1'b1;
                    wb_dat_i = rdf(wb_adr_o);
                end
                beats.push_back('{wb_adr_o, wb_we_o, wb_dat_o, beat_idx == err_at});
                beat_idx++;
                wcnt    = 0;
                cur_lat = $urandom_range(0, max_lat);
            end else begin
                wcnt++;
            end
        end else if (!wb_stb_o) begin
            wcnt = 0;
        end
    end

    // Observers for pulses, cyc continuity, sel and the read stream.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err) begin err_cnt++; err_cyc = cyc_n; end
        if (done && err) both_bad++;
        if (err && wb_cyc_o) errcyc_bad++;
        if (wb_stb_o && (wb_sel_o != 4'hF || !wb_cyc_o)) sel_bad++;
        if (wb_stb_o) stb_cycles++;
        if (prev_cyc && !wb_cyc_o) cyc_falls++;
        if (wb_stb_o && !prev_stb) stb_rise_cyc = cyc_n;
        if (rd_valid && rd_ready) rd_q.push_back(rd_data);
        wr_hs    = wr_valid && wr_ready;
        prev_cyc = wb_cyc_o;
        prev_stb = wb_stb_o;
    end

    always @(posedge clk) cyc_n++;

    // Read-stream sink: 0 = always ready, 1 = stalled, other = random.
    always @(posedge clk) begin
        #1;
        case (rd_mode)
            0:       rd_ready = 1'b1;
            1:       rd_ready = 1'b0;
            default: rd_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    // Write-stream source: wr_gap idle cycles between words.
    always @(posedge clk) begin
        #1;
        if (wr_hs) begin
            void'(wq.pop_front());
            wr_valid = 1'b0;
            wr_hs    = 1'b0;
            gap_left = wr_gap;
        end else if (!wr_valid) begin
            if (gap_left > 1) begin
                gap_left--;
            end else begin
                gap_left = 0;
                if (wq.size() > 0) begin
                    wr_valid = 1'b1;
                    wr_data  = wq[0];
                end
            end
        end
    end

    task automatic prep(input logic [15:0] a, input int l, input bit w, input int lat,
                        input int ea, input int gap, input int rmode);
        max_lat = lat; err_at = ea; wr_gap = gap; rd_mode = rmode; noack = 1'b0;
        salt = $urandom;
        cur_a = a; cur_l = l; cur_w = w;
        beats.delete(); rd_q.delete(); exp_w.delete();
        beat_idx = 0; cur_lat = $urandom_range(0, lat);
        done_cnt = 0; err_cnt = 0; cyc_falls = 0; sel_bad = 0;
        both_bad = 0; errcyc_bad = 0; stb_cycles = 0;
        if (w) begin
            for (int i = 0; i <= l; i++) begin
                exp_w.push_back((fixed_w.size() > i) ? fixed_w[i] : $urandom);
                wq.push_back(exp_w[i]);
            end
        end
        fixed_w.delete();
    endtask

    task automatic start_cmd();
        int n = 0;
        while (!cmd_ready && n < 100) begin @(posedge clk); #1; n++; end
        chk("cmd_ready_wait", 64'(n < 100), 64'd1);
        cmd_addr = cur_a; cmd_len = 8'(cur_l); cmd_we = cur_w; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Waits for the end pulse, then compares everything the command produced with the model.
    task automatic post(input string tag);
        bit ok = 1'b0;
        bit aborted;
        int nb, nrd;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (done || err) begin ok = 1'b1; break; end
        end
        repeat (2) @(posedge clk);
        #1;
        chk({tag, " finished"}, 64'(ok), 64'd1);
        aborted = (err_at >= 0) && (err_at <= cur_l);
        nb  = aborted ? err_at + 1 : cur_l + 1;
        nrd = cur_w ? 0 : (aborted ? err_at : cur_l + 1);
        chk({tag, " beat count"}, 64'(beats.size()), 64'(nb));
        for (int i = 0; i < nb && i < beats.size(); i++) begin
            chk($sformatf("%s beat%0d adr", tag, i), 64'(beats[i].adr), 64'(16'(cur_a + i)));
            chk($sformatf("%s beat%0d we", tag, i), 64'(beats[i].we), 64'(cur_w));
            if (cur_w)
                chk($sformatf("%s beat%0d dat", tag, i), 64'(beats[i].dat), 64'(exp_w[i]));
        end
        chk({tag, " rd count"}, 64'(rd_q.size()), 64'(nrd));
        for (int i = 0; i < nrd && i < rd_q.size(); i++)
            chk($sformatf("%s rd%0d", tag, i), 64'(rd_q[i]), 64'(rdf(16'(cur_a + i))));
        if (max_lat == 0) chk({tag, " stb cycles"}, 64'(stb_cycles), 64'(nb));
        chk({tag, " done pulses"}, 64'(done_cnt), aborted ? 64'd0 : 64'd1);
        chk({tag, " err pulses"}, 64'(err_cnt), aborted ? 64'd1 : 64'd0);
        chk({tag, " cyc falls"}, 64'(cyc_falls), 64'd1);
        chk({tag, " protocol"}, 64'(sel_bad + both_bad + errcyc_bad), 64'd0);
        chk({tag, " idle after"}, 64'({busy, wb_cyc_o, rd_valid, cmd_ready}), 64'b0001);
    endtask

    task automatic do_cmd(input string tag, input logic [15:0] a, input int l, input bit w,
                          input int lat, input int ea, input int gap, input int rmode);
        prep(a, l, w, lat, ea, gap, rmode);
        start_cmd();
        post(tag);
    endtask

    initial begin
        bit ok;
        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset status", 64'({busy, done, err, rd_valid, wr_ready}), 64'd0);
        chk("reset bus", 64'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}), 64'd0);
        chk("reset adr/dat", 64'({wb_adr_o, wb_dat_o}), 64'd0);
        chk("reset rd_data", 64'(rd_data), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle cmd_ready", 64'(cmd_ready), 64'd1);

        // directed read burst, single-cycle acks
        do_cmd("read4", 16'h0010, 3, 1'b0, 0, -1, 0, 0);

        // directed write with gapped write data
        fixed_w.push_back(32'hA5A5A5A5);
        fixed_w.push_back(32'h5A5A5A5A);
        do_cmd("write2", 16'h0100, 1, 1'b1, 0, -1, 3, 0);

        // read backpressure: no second beat until the first word is drained
        prep(16'h0200, 2, 1'b0, 0, -1, 0, 1);
        start_cmd();
        repeat (10) @(posedge clk);
        #1;
        chk("bp beats while stalled", 64'(beats.size()), 64'd1);
        chk("bp stb while stalled", 64'({wb_stb_o, wb_cyc_o, rd_valid}), 64'b011);
        rd_mode = 0;
        post("bp");

        // bus error on the second beat of a 5-beat read
        do_cmd("abort", 16'h0300, 4, 1'b0, 0, 1, 0, 0);

        // timeout: no response at all
        prep(16'h0400, 0, 1'b0, 0, -1, 0, 0);
        noack = 1'b1;
        start_cmd();
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (err) begin ok = 1'b1; break; end
        end
        repeat (2) @(posedge clk);
        #1;
        chk("timeout err seen", 64'(ok), 64'd1);
        chk("timeout latency", 64'(err_cyc - stb_rise_cyc), 64'd8);
        chk("timeout pulses", 64'({done_cnt[7:0], err_cnt[7:0]}), 64'h0001);
        chk("timeout idle", 64'({busy, wb_cyc_o, wb_stb_o}), 64'd0);
        noack = 1'b0;

        // address wrap
        do_cmd("wrap", 16'hFFFE, 3, 1'b0, 0, -1, 0, 0);

        // asynchronous reset in the middle of a beat
        prep(16'h0055, 2, 1'b0, 0, -1, 0, 0);
        noack = 1'b1;
        start_cmd();
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (wb_stb_o) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        chk("arst stb up", 64'(ok), 64'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst async drop", 64'({wb_cyc_o, wb_stb_o, busy}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        noack = 1'b0;
        do_cmd("after arst", 16'h0777, 2, 1'b0, 0, -1, 0, 0);

        // randomized commands
        for (int t = 0; t < 8; t++) begin
            logic [15:0] ra;
            int rl, rlat, rea, rgap;
            bit rw;
            ra   = 16'($urandom);
            rl   = $urandom_range(0, 6);
            rw   = 1'($urandom_range(0, 1));
            rlat = $urandom_range(0, 2);
            rgap = $urandom_range(0, 2);
            rea  = (!rw && $urandom_range(0, 3) == 0) ? $urandom_range(0, rl) : -1;
            do_cmd($sformatf("rand%0d", t), ra, rl, rw, rlat, rea, rgap, rw ? 0 : 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
